ql_ioff_scan_ctrl: RTL and testbench
====================================

QL_IOFF_SCAN_CTRL -- requirements
Module: ql_ioff_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 32, meaning the number of scan-chained IO flip-flops driven; legal range 2..64.
REQ-002 The block SHALL have port CK  input  1  chain/controller clock; all state updates on rising edge.
REQ-003 The block SHALL have port global_resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  request one chain operation; sampled on the rising CK edge.
REQ-005 The block SHALL have port op_read  input  1  operation select at start: 0 = write (shift wr_data in), 1 = non-destructive read (recirculate).
REQ-006 The block SHALL have port wr_data  input  CHAIN_LEN  word to shift into the chain on a write.
REQ-007 The block SHALL have port busy  output  1  operation in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port rd_data  output  CHAIN_LEN  bits shifted out of the chain by the last operation.
REQ-010 The block SHALL have port scan_se  output  1  drives SE of every chained IO flip-flop.
REQ-011 The block SHALL have port scan_si  output  1  drives SI of the first chained IO flip-flop.
REQ-012 The block SHALL have port scan_so  input  1  SO of the last chained IO flip-flop.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE; the reset state is IDLE.
REQ-014 Transitions SHALL be: IDLE->SHIFT on start=1; SHIFT->DONE after exactly CHAIN_LEN SHIFT cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-015 On start accepted in IDLE, op_read SHALL be latched and wr_data SHALL be loaded into an internal CHAIN_LEN-bit shift register sreg.
REQ-016 start SHALL be ignored in SHIFT and DONE, with no queuing.
REQ-017 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide, cleared on start accept, and incremented once per SHIFT cycle.
REQ-018 scan_se SHALL be a registered output equal to 1 in every SHIFT cycle and 0 in IDLE and DONE, so the chain runs functional between operations.
REQ-019 scan_si SHALL equal sreg[0] when the latched op_read is 0, and scan_so combinationally when the latched op_read is 1; scan_si SHALL be 0 outside SHIFT.
REQ-020 At the rising edge ending each SHIFT cycle, sreg SHALL update to {scan_so, sreg[CHAIN_LEN-1:1]}, sampling scan_so before the chain shifts on that same edge.
REQ-021 Consequences of REQ-019/REQ-020 on a write: wr_data[0] enters first and ends adjacent to scan_so; rd_data[0] is the first bit shifted out.
REQ-022 On entry to DONE, rd_data SHALL be loaded from sreg and held until the next DONE; done SHALL be 1 for the single DONE cycle only.
REQ-023 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-024 Latency: with start accepted at edge E0, busy SHALL rise after E0, scan_se SHALL be high for CHAIN_LEN cycles, and done SHALL be high in cycle CHAIN_LEN+1 after E0.
REQ-025 A read SHALL leave chain contents identical to their pre-operation values.
REQ-026 Back-to-back operations SHALL be possible with start asserted in the first IDLE cycle after DONE, giving a minimum start-to-start spacing of CHAIN_LEN+2 cycles.

Reset
REQ-027 While global_resetn=0, outputs SHALL asynchronously be: busy=0, done=0, scan_se=0, scan_si=0, rd_data=0; FSM=IDLE; counter=0; sreg=0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; rd_data SHALL stay 0 and the partially shifted chain SHALL be left as is.
REQ-029 The first start SHALL be accepted at the first rising CK edge after global_resetn deasserts.

Verification (CHAIN_LEN=8, bench models 8 chained scan flops, initial contents 0)
REQ-030 Reset -> all outputs 0, scan_se=0 while start is held 0.
REQ-031 Write wr_data=0xA5 -> scan_se high exactly 8 cycles, done in cycle 9 after start edge, rd_data=0x00.
REQ-032 Write 0x3C following REQ-031 -> rd_data=0xA5 (loopback of previous write).
REQ-033 Read (op_read=1) twice following REQ-032 -> rd_data=0x3C both times, chain model still 0x3C.
REQ-034 start pulsed during SHIFT and during DONE -> ignored; exactly one done pulse; rd_data unchanged from the accepted op.
REQ-035 global_resetn low at SHIFT cycle 4 -> busy/scan_se/scan_si drop to 0 immediately, no done pulse, rd_data=0; a subsequent write completes normally.

Source files
------------

// File: rtl/ql_ioff_scan_ctrl.sv
// ql_ioff_scan_ctrl: serial controller for a chain of scan-connected IO flip-flops.
// One operation shifts the whole chain by CHAIN_LEN positions. A write shifts wr_data
// in; a read recirculates SO back into SI so the chain ends where it started. Either
// way the bits leaving the chain are captured and presented on rd_data.
//
// Ports:
//   CK            chain/controller clock, rising edge
//   global_resetn asynchronous active-low reset
//   start         request an operation (accepted only when idle)
//   op_read       0 = write wr_data, 1 = non-destructive read
//   wr_data       word shifted in on a write; bit 0 enters the chain first
//   busy          operation in progress (SHIFT and DONE)
//   done          one-cycle completion pulse
//   rd_data       bits shifted out by the last completed operation; bit 0 came out first
//   scan_se       scan enable to every chained flop
//   scan_si       scan input of the first chained flop
//   scan_so       scan output of the last chained flop
module ql_ioff_scan_ctrl #(
  parameter int unsigned CHAIN_LEN = 32
) (
  input  logic                 CK,
  input  logic                 global_resetn,
  input  logic                 start,
  input  logic                 op_read,
  input  logic [CHAIN_LEN-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_cnt;
  logic [CHAIN_LEN-1:0] r_sreg;
  logic [CHAIN_LEN-1:0] r_rd_data;
  logic                 r_op_read;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_scan_se;

  logic [CHAIN_LEN-1:0] w_sreg_shift;
  logic                 w_scan_si;

  always_comb begin
    // scan_so is sampled on the same edge that shifts the chain, so it is the old last bit.
    w_sreg_shift = {scan_so, r_sreg[CHAIN_LEN-1:1]};
    // r_scan_se is high exactly in SHIFT, so it doubles as the SI gate.
    w_scan_si    = r_scan_se & (r_op_read ? scan_so : r_sreg[0]);
  end

  always_ff @(posedge CK or negedge global_resetn) begin
    if (!global_resetn) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_sreg    <= '0;
      r_rd_data <= '0;
      r_op_read <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_scan_se <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state   <= StShift;
            r_cnt     <= '0;
            r_sreg    <= wr_data;
            r_op_read <= op_read;
            r_busy    <= 1'b1;
            r_scan_se <= 1'b1;
          end
        end
        StShift: begin
          r_sreg <= w_sreg_shift;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_state   <= StDone;
            r_scan_se <= 1'b0;
            r_done    <= 1'b1;
            r_rd_data <= w_sreg_shift;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= StIdle;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_scan_se <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_data = r_rd_data;
  assign scan_se = r_scan_se;
  assign scan_si = w_scan_si;

endmodule

// File: tb/tb_ql_ioff_scan_ctrl.sv
// Bench for ql_ioff_scan_ctrl with CHAIN_LEN=8 and an 8-flop scan chain model.
// Stimulus pushes the expected rd_data into a queue; a monitor pops it on each done pulse.
module tb_ql_ioff_scan_ctrl;

  localparam int unsigned N = 8;

  logic         CK;
  logic         global_resetn;
  logic         start;
  logic         op_read;
  logic [N-1:0] wr_data;
  logic         busy;
  logic         done;
  logic [N-1:0] rd_data;
  logic         scan_se;
  logic         scan_si;
  logic         scan_so;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] mon_exp;

  // External chain: chain[0] fed by SI, chain[7] drives SO. Not reset.
  logic [N-1:0] chain = '0;
  always @(posedge CK) if (scan_se) chain <= {chain[N-2:0], scan_si};
  assign scan_so = chain[N-1];

  ql_ioff_scan_ctrl #(.CHAIN_LEN(N)) dut (
    .CK            (CK),
    .global_resetn (global_resetn),
    .start         (start),
    .op_read       (op_read),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .rd_data       (rd_data),
    .scan_se       (scan_se),
    .scan_si       (scan_si),
    .scan_so       (scan_so)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Chain contents in rd_data order: word bit i leaves the chain i-th.
  function automatic logic [N-1:0] chain_word(input logic [N-1:0] c);
    logic [N-1:0] w;
    for (int i = 0; i < N; i++) w[i] = c[N-1-i];
    return w;
  endfunction

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge CK) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1 expected no pulse at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", {24'h0, rd_data}, {24'h0, mon_exp});
      end
    end
  end

  // Call at a negedge. Returns at the negedge of the first IDLE cycle after DONE.
  task automatic do_op(input logic rd, input logic [N-1:0] d, input logic [N-1:0] exp,
                       input bit pulses);
    int se_cnt;
    int done_cnt;
    int done_cyc;
    start   = 1'b1;
    op_read = rd;
    wr_data = d;
    exp_q.push_back(exp);
    se_cnt   = 0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CK);
      if (c == 1) begin
        start   = 1'b0;
        op_read = ~rd;  // must already be latched
        wr_data = ~d;
        check("busy_after_start", {31'h0, busy}, 32'h1);
      end
      if (pulses && (c == 3 || c == 9)) start = 1'b1;
      if (c == 4 || c == 10) start = 1'b0;
      if (scan_se) se_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
    check("scan_se_cycles", se_cnt, 32'd8);
    check("done_count", done_cnt, 32'd1);
    check("done_cycle", done_cyc, 32'd9);
    check("busy_idle", {31'h0, busy}, 32'h0);
    check("scan_se_idle", {31'h0, scan_se}, 32'h0);
    check("scan_si_idle", {31'h0, scan_si}, 32'h0);
  endtask

  initial begin
    global_resetn = 1'b0;
    start         = 1'b0;
    op_read       = 1'b0;
    wr_data       = '0;
    #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_scan_se", {31'h0, scan_se}, 32'h0);
    check("rst_scan_si", {31'h0, scan_si}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    repeat (3) @(negedge CK);
    check("rst_scan_se_hold", {31'h0, scan_se}, 32'h0);

    // Release and start on the same cycle: first edge after release accepts it.
    global_resetn = 1'b1;
    do_op(1'b0, 8'hA5, 8'h00, 1'b0);
    check("chain_after_a5", {24'h0, chain_word(chain)}, 32'hA5);
    // Back-to-back: start in the first IDLE cycle after DONE.
    do_op(1'b0, 8'h3C, 8'hA5, 1'b0);
    check("chain_after_3c", {24'h0, chain_word(chain)}, 32'h3C);
    do_op(1'b1, 8'h00, 8'h3C, 1'b0);
    do_op(1'b1, 8'hFF, 8'h3C, 1'b0);
    check("chain_after_reads", {24'h0, chain_word(chain)}, 32'h3C);

    // Spurious starts during SHIFT and DONE must be ignored, not queued.
    do_op(1'b0, 8'h96, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CK);
      check("no_queued_op", {31'h0, busy}, 32'h0);
    end
    check("rd_data_held", {24'h0, rd_data}, 32'h3C);
    check("chain_after_96", {24'h0, chain_word(chain)}, 32'h96);

    // Reset in the 4th SHIFT cycle of a write of 0xFF (3 shifts done).
    start   = 1'b1;
    op_read = 1'b0;
    wr_data = 8'hFF;
    @(negedge CK);
    start = 1'b0;
    @(negedge CK);
    @(negedge CK);
    @(negedge CK);
    check("shift_before_rst", {31'h0, scan_se}, 32'h1);
    global_resetn = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_scan_se", {31'h0, scan_se}, 32'h0);
    check("abort_scan_si", {31'h0, scan_si}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_rd_data", {24'h0, rd_data}, 32'h0);
    repeat (2) @(negedge CK);
    check("chain_partial", {24'h0, chain_word(chain)}, 32'hF2);
    global_resetn = 1'b1;
    do_op(1'b0, 8'h00, 8'hF2, 1'b0);
    check("chain_after_00", {24'h0, chain_word(chain)}, 32'h00);

    repeat (2) @(negedge CK);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
